// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the request/response handshake, memory-system
// bus and result registers of mem_access_unit.
//   slave  : the mem_access_unit side (drives ready/resp/mem/IR/MDR)
//   master : the control/datapath + memory-system side (drives req_*,
//            resp_ready and the combinational read data)
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] mem_Address_o;
  logic [DATA_WIDTH-1:0] mem_Write_Data_o;
  logic                  mem_Enable_o;
  logic [DATA_WIDTH-1:0] mem_Read_Data_i;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_fault;
  logic [DATA_WIDTH-1:0] IR_o;
  logic [DATA_WIDTH-1:0] MDR_o;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_Read_Data_i, resp_ready,
    output req_ready, mem_Address_o, mem_Write_Data_o, mem_Enable_o,
           resp_valid, resp_fault, IR_o, MDR_o
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_Read_Data_i, resp_ready,
    input  req_ready, mem_Address_o, mem_Write_Data_o, mem_Enable_o,
           resp_valid, resp_fault, IR_o, MDR_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one fetch/load/store into the unified memory
// system, checks alignment and region, and latches the result into IR/MDR.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - mem_access_unit_if.slave (request, response, memory bus, IR/MDR)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for a request (req_ready = 1)
// S_ACCESS | single memory access cycle; write enable only for stores
// S_RESP   | response held (resp_valid = 1) until resp_ready
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter int unsigned TEXT_WORDS = 64,
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int unsigned DATA_WORDS = 64
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [DATA_WIDTH-1:0] T_BASE = DATA_WIDTH'(TEXT_BASE);
  localparam logic [DATA_WIDTH-1:0] T_END  = DATA_WIDTH'(TEXT_BASE) + DATA_WIDTH'(4 * TEXT_WORDS);
  localparam logic [DATA_WIDTH-1:0] D_BASE = DATA_WIDTH'(DATA_BASE);
  localparam logic [DATA_WIDTH-1:0] D_END  = DATA_WIDTH'(DATA_BASE) + DATA_WIDTH'(4 * DATA_WORDS);

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  fault_q, fault_d;

  logic in_text, in_data, req_fault;

  always_comb begin
    in_text   = (bus.req_addr >= T_BASE) && (bus.req_addr < T_END);
    in_data   = (bus.req_addr >= D_BASE) && (bus.req_addr < D_END);
    req_fault = (bus.req_addr[1:0] != 2'b00);
    case (bus.req_op)
      OP_FETCH: if (!in_text)              req_fault = 1'b1;
      OP_LOAD:  if (!in_text && !in_data)  req_fault = 1'b1;
      OP_STORE: if (!in_data)              req_fault = 1'b1;
      default:                             req_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          fault_d = req_fault;
          state_d = req_fault ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (op_q == OP_FETCH) ir_d  = bus.mem_Read_Data_i;
        if (op_q == OP_LOAD)  mdr_d = bus.mem_Read_Data_i;
        fault_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      fault_q <= fault_d;
    end
  end

  // Decoded straight from registered state, so reset removes the write
  // enable asynchronously and it can never pulse outside ACCESS.
  assign bus.mem_Enable_o     = (state_q == S_ACCESS) && (op_q == OP_STORE);
  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.resp_valid       = (state_q == S_RESP);
  assign bus.resp_fault       = fault_q;
  assign bus.mem_Address_o    = addr_q;
  assign bus.mem_Write_Data_o = wdata_q;
  assign bus.IR_o             = ir_q;
  assign bus.MDR_o            = mdr_q;

endmodule
